// File: rtl/me_result_collector.sv
// Collects one {blk_idx, BestDist, motionX, motionY} result per ME block search into a FIFO
// with a valid/ready output and sticky overflow. Define ME_STATS_EN for the sad_sum/zero_mv statistics.
module me_result_collector #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8,
  parameter int SUM_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     completed,
  input  logic [7:0]               BestDist,
  input  logic [3:0]               motionX,
  input  logic [3:0]               motionY,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W+15:0]        out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [1:0]               fsm_state
`ifdef ME_STATS_EN
  ,
  output logic [SUM_W-1:0]         sad_sum,
  output logic [7:0]               zero_mv
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = IDX_W + 16;

  // Output handshake: an entry transfers at a rising clock edge where
  // out_valid & out_ready are both high; out_valid/out_data are registered,
  // always reflect the current FIFO head, and out_data reads 0 when empty.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                comp_prev_q, comp_prev_d;
  logic                comp_rise;
  logic                capture;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]    blk_idx_q, blk_idx_d;
  logic                overflow_q, overflow_d;

  logic                full;
  logic                pop;
  logic                accept;
  logic                drop;
  logic [DATA_W-1:0]   entry;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      comp_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_prev_q <= comp_prev_d;
    end
  end

  assign comp_rise   = completed & ~comp_prev_q;
  assign comp_prev_d = completed;

  // ---------------- FSM: next state ----------------
  // A completion rise wins over a same-edge drop of start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SEARCH;
      S_SEARCH: begin
        if (comp_rise)   state_d = S_DONE;
        else if (!start) state_d = S_IDLE;
      end
      S_DONE:   if (!start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    capture   = 1'b0;
    fsm_state = state_q;
    if (state_q == S_SEARCH && comp_rise) capture = 1'b1;
  end

  // ---------------- FIFO datapath ----------------
  assign fill_q = wr_ptr_q - rd_ptr_q;
  assign full   = (fill_q == DEPTH[PTR_W:0]);
  assign pop    = out_valid_q & out_ready;
  assign accept = capture & (~full | pop);
  assign drop   = capture & full & ~pop;
  assign entry  = {blk_idx_q, BestDist, motionX, motionY};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (accept) mem_d[wr_ptr_q[PTR_W-1:0]] = entry;
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, accept};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    fill_d   = wr_ptr_d - rd_ptr_d;
  end

  // Reading the head from mem_d lets a write into an empty FIFO show up
  // on out_data right after the capture edge.
  always_comb begin
    out_valid_d = (fill_d != '0);
    out_data_d  = '0;
    if (out_valid_d) out_data_d = mem_d[rd_ptr_d[PTR_W-1:0]];
  end

  always_comb begin
    blk_idx_d  = blk_idx_q + {{(IDX_W-1){1'b0}}, capture};
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      blk_idx_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      blk_idx_q   <= blk_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fill      = fill_q;
  assign overflow  = overflow_q;

`ifdef ME_STATS_EN
  // ---------------- statistics over accepted captures ----------------
  logic [SUM_W-1:0] sad_sum_q, sad_sum_d;
  logic [7:0]       zero_mv_q, zero_mv_d;
  logic [SUM_W:0]   sum_ext;

  assign sum_ext = {1'b0, sad_sum_q} + {{(SUM_W-7){1'b0}}, BestDist};

  always_comb begin
    sad_sum_d = sad_sum_q;
    zero_mv_d = zero_mv_q;
    if (ovf_clr) begin
      sad_sum_d = '0;
      zero_mv_d = '0;
    end else if (accept) begin
      sad_sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (motionX == 4'h0 && motionY == 4'h0 && zero_mv_q != 8'hFF)
        zero_mv_d = zero_mv_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sad_sum_q <= '0;
      zero_mv_q <= '0;
    end else begin
      sad_sum_q <= sad_sum_d;
      zero_mv_q <= zero_mv_d;
    end
  end

  assign sad_sum = sad_sum_q;
  assign zero_mv = zero_mv_q;
`endif

endmodule

// File: tb/tb_me_result_collector.sv
// Self-checking bench for me_result_collector: a cycle vector table plus
// directed sequences for full/overflow, reset and (with ME_STATS_EN) statistics.
module tb_me_result_collector;

  logic        clock;
  logic        reset;
  logic        start;
  logic        completed;
  logic [7:0]  BestDist;
  logic [3:0]  motionX;
  logic [3:0]  motionY;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [3:0]  fill;
  logic        overflow;
  logic        ovf_clr;
  logic [1:0]  fsm_state;
`ifdef ME_STATS_EN
  logic [15:0] sad_sum;
  logic [7:0]  zero_mv;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic        bg_ready = 1'b0;
  logic [23:0] exp_q[$];

  me_result_collector dut (
    .clock(clock), .reset(reset), .start(start), .completed(completed),
    .BestDist(BestDist), .motionX(motionX), .motionY(motionY),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill(fill), .overflow(overflow), .ovf_clr(ovf_clr), .fsm_state(fsm_state)
`ifdef ME_STATS_EN
    , .sad_sum(sad_sum), .zero_mv(zero_mv)
`endif
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        completed;
    logic [7:0]  bd;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        rdy;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic [3:0]  exp_fill;
    logic        exp_ovf;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; completed = 0; out_ready = 0; ovf_clr = 0;
    BestDist = 0; motionX = 0; motionY = 0; bg_ready = 0;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic do_search(input logic [7:0] bd, input logic [3:0] x, input logic [3:0] y,
                           input logic rdy_cap, input logic clr_cap);
    start = 1; completed = 0; out_ready = bg_ready; ovf_clr = 0;
    @(posedge clock); #1;
    completed = 1; BestDist = bd; motionX = x; motionY = y;
    out_ready = rdy_cap; ovf_clr = clr_cap;
    @(posedge clock); #1;
    start = 0; completed = 0; out_ready = bg_ready; ovf_clr = 0;
    @(posedge clock); #1;
  endtask

  function automatic logic [23:0] mk(input logic [7:0] idx, input logic [7:0] bd,
                                     input logic [3:0] x, input logic [3:0] y);
    return {idx, bd, x, y};
  endfunction

  task automatic fill_eight();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      do_search(8'h10 + iv, iv[3:0], ~iv[3:0], 1'b0, 1'b0);
      exp_q.push_back(mk(iv, 8'h10 + iv, iv[3:0], ~iv[3:0]));
    end
  endtask

  task automatic drain(input int n, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clock); #1; t++;
      end
      if (!out_valid) begin
        n_checks++; n_errors++;
        $display("FAIL %s_timeout: out_valid stayed 0, entry %0d required", tag, k);
      end else if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL %s_extra: got entry 0x%0h, none required", tag, out_data);
      end else begin
        check({tag, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
      end
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 8'h00, 4'h0, 4'h0, 0, 0, 24'h000000, 4'd0, 0, 2'd1};
    vecs[1]  = '{1, 1, 8'h12, 4'hD, 4'h3, 0, 1, 24'h0012D3, 4'd1, 0, 2'd2};
    vecs[2]  = '{1, 1, 8'h12, 4'hD, 4'h3, 0, 1, 24'h0012D3, 4'd1, 0, 2'd2};
    vecs[3]  = '{1, 1, 8'h99, 4'h1, 4'h1, 0, 1, 24'h0012D3, 4'd1, 0, 2'd2};
    vecs[4]  = '{0, 1, 8'h99, 4'h1, 4'h1, 0, 1, 24'h0012D3, 4'd1, 0, 2'd0};
    vecs[5]  = '{1, 1, 8'h99, 4'h1, 4'h1, 0, 1, 24'h0012D3, 4'd1, 0, 2'd1};
    vecs[6]  = '{1, 1, 8'h99, 4'h1, 4'h1, 0, 1, 24'h0012D3, 4'd1, 0, 2'd1};
    vecs[7]  = '{0, 0, 8'h99, 4'h1, 4'h1, 0, 1, 24'h0012D3, 4'd1, 0, 2'd0};
    vecs[8]  = '{1, 0, 8'h00, 4'h0, 4'h0, 1, 0, 24'h000000, 4'd0, 0, 2'd1};
    vecs[9]  = '{0, 0, 8'h00, 4'h0, 4'h0, 1, 0, 24'h000000, 4'd0, 0, 2'd0};
    vecs[10] = '{1, 0, 8'h00, 4'h0, 4'h0, 1, 0, 24'h000000, 4'd0, 0, 2'd1};
    vecs[11] = '{1, 1, 8'h34, 4'h0, 4'h7, 1, 1, 24'h013407, 4'd1, 0, 2'd2};
    vecs[12] = '{0, 0, 8'h00, 4'h0, 4'h0, 1, 0, 24'h000000, 4'd0, 0, 2'd0};

    // ---------------- reset state ----------------
    reset = 1; start = 0; completed = 0; out_ready = 0; ovf_clr = 0;
    BestDist = 0; motionX = 0; motionY = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 0;
    @(posedge clock); #1;

    // ---------------- vector table: capture, hold, abort, index ----------------
    for (int v = 0; v < 13; v++) begin
      start = vecs[v].start; completed = vecs[v].completed;
      BestDist = vecs[v].bd; motionX = vecs[v].x; motionY = vecs[v].y;
      out_ready = vecs[v].rdy; ovf_clr = 1'b0;
      @(posedge clock); #1;
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_fill", v), 32'(fill), 32'(vecs[v].exp_fill));
      check($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_state", v), 32'(fsm_state), 32'(vecs[v].exp_state));
    end

    // ---------------- full FIFO, drop, drain order, index continuity ----------------
    do_reset();
    fill_eight();
    check("full_fill", 32'(fill), 32'd8);
    check("full_ovf_before", 32'(overflow), 32'd0);
    do_search(8'hEE, 4'h5, 4'h5, 1'b0, 1'b0);
    check("drop_fill", 32'(fill), 32'd8);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_head_idx", 32'(out_data[23:16]), 32'd0);
    drain(8, "drain8");
    check("drained_fill", 32'(fill), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);
    do_search(8'h55, 4'h1, 4'h2, 1'b0, 1'b0);
    check("idx_after_drop", 32'(out_data), 32'(mk(8'd9, 8'h55, 4'h1, 4'h2)));
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1; @(posedge clock); #1; ovf_clr = 0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // ---------------- clear and new overflow at the same edge ----------------
    do_reset();
    fill_eight();
    do_search(8'hEE, 4'h5, 4'h5, 1'b0, 1'b1);
    check("set_wins_ovf", 32'(overflow), 32'd1);
    ovf_clr = 1; @(posedge clock); #1; ovf_clr = 0;
    check("set_wins_clr", 32'(overflow), 32'd0);

    // ---------------- capture and pop at the same edge while full ----------------
    do_reset();
    fill_eight();
    check("fullpop_head", 32'(out_data), 32'(exp_q[0]));
    do_search(8'hA5, 4'h8, 4'h7, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(mk(8'd8, 8'hA5, 4'h8, 4'h7));
    check("fullpop_fill", 32'(fill), 32'd8);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    drain(8, "fullpop");
    check("fullpop_empty", 32'(fill), 32'd0);

    // ---------------- reset mid-search with a non-empty FIFO ----------------
    do_reset();
    for (int i = 0; i < 3; i++) do_search(8'h20, 4'h2, 4'h2, 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill), 32'd3);
    start = 1; completed = 0;
    @(posedge clock); #1;
    completed = 1;
    reset = 1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_fill", 32'(fill), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check($sformatf("post_rst_nocap%0d", i), 32'({out_valid, fill}), 32'd0);
    end
    start = 0; completed = 0;
    @(posedge clock); #1;
    do_search(8'h77, 4'h0, 4'hF, 1'b0, 1'b0);
    check("post_rst_first", 32'(out_data), 32'(mk(8'd0, 8'h77, 4'h0, 4'hF)));

`ifdef ME_STATS_EN
    // ---------------- statistics saturation and clear ----------------
    do_reset();
    bg_ready = 1'b1;
    for (int i = 0; i < 2; i++) do_search(8'hFF, 4'h0, 4'h0, 1'b1, 1'b0);
    check("stats_sum2", 32'(sad_sum), 32'h1FE);
    check("stats_zmv2", 32'(zero_mv), 32'd2);
    for (int i = 0; i < 298; i++) do_search(8'hFF, 4'h0, 4'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("stats_sum_sat", 32'(sad_sum), 32'hFFFF);
    check("stats_zmv_sat", 32'(zero_mv), 32'hFF);
    check("stats_fill", 32'(fill), 32'd0);
    ovf_clr = 1; @(posedge clock); #1; ovf_clr = 0;
    check("stats_sum_clr", 32'(sad_sum), 32'd0);
    check("stats_zmv_clr", 32'(zero_mv), 32'd0);
    bg_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
